// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage and its load formatter.
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = 8;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} wb_state_e;

  // Controls captured when a load has to wait for memory
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic       reg_write;
    logic [4:0] reg_dest;
    logic       pc_src;
  } wb_ctrl_t;
endpackage

// File: rtl/load_align.sv
// Combinational load formatter: byte/half/word select with sign/zero extension.
module load_align import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  output logic [XLEN-1:0] data,
  output logic            err
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (addr)
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
    data = '0;
    err  = 1'b0;
    case (funct3)
      LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LH:  begin err = addr[0]; data = {{(XLEN-16){half_sel[15]}}, half_sel}; end
      LHU: begin err = addr[0]; data = {{(XLEN-16){1'b0}}, half_sel}; end
      LW:  begin err = (addr != 2'b00); data = raw; end
      default: err = 1'b1;
    endcase
    // Faulting loads must not leak partial data into the register file
    if (err) data = '0;
  end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: load formatting, write-back select, memory-wait stall with timeout.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired instruction counter.
module writeback_stage import wb_pkg::*; #(
  parameter int XLEN        = XLEN_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic            in_mem_done,
  input  logic [2:0]      in_funct3,
  input  logic            in_MemToReg,
  input  logic            in_RegWrite,
  input  logic [4:0]      in_RegDest,
  input  logic            in_RegDataSrc,
  input  logic            in_PCSrc,
  output logic            stall,
  output logic            rf_write_enable,
  output logic [4:0]      rf_write_addr,
  output logic [XLEN-1:0] rf_write_data,
  output logic            wb_valid,
  output logic            out_PCSrc,
  output logic            load_err,
  output logic            mem_timeout
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retired_count
`endif
);
  wb_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_ctrl_t   lat_q;
  logic       latch_en, commit, use_lat, tmo;

  // Effective controls: live inputs in IDLE, latched copies in WAIT_MEM
  logic [2:0]      c_f3;
  logic [1:0]      c_addr;
  logic            c_m2r, c_rw, c_pcsrc, c_err;
  logic [4:0]      c_rd;
  logic [XLEN-1:0] ld_data, sel_data;
  logic            ld_err;

  assign stall = rst & ((state_q == WAIT_MEM) ||
                        (state_q == IDLE && in_valid && in_MemToReg && !in_mem_done));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    use_lat  = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        if (in_MemToReg && !in_mem_done) begin
          state_d  = WAIT_MEM;
          cnt_d    = '0;
          latch_en = 1'b1;
        end else begin
          commit = 1'b1;
        end
      end
      WAIT_MEM: begin
        use_lat = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (in_mem_done) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign c_f3    = use_lat ? lat_q.funct3    : in_funct3;
  assign c_addr  = use_lat ? lat_q.addr_lo   : in_alu_result[1:0];
  assign c_m2r   = use_lat | in_MemToReg;
  assign c_rw    = use_lat ? lat_q.reg_write : in_RegWrite;
  assign c_rd    = use_lat ? lat_q.reg_dest  : in_RegDest;
  assign c_pcsrc = use_lat ? lat_q.pc_src    : in_PCSrc;

  load_align #(.XLEN(XLEN)) u_align (
    .raw    (in_mem_data),
    .funct3 (c_f3),
    .addr   (c_addr),
    .data   (ld_data),
    .err    (ld_err)
  );

  assign c_err    = c_m2r & ld_err;
  assign sel_data = c_m2r ? ld_data : (in_RegDataSrc ? in_pc_plus4 : in_alu_result);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en)
        lat_q <= '{funct3: in_funct3, addr_lo: in_alu_result[1:0], reg_write: in_RegWrite,
                   reg_dest: in_RegDest, pc_src: in_PCSrc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      wb_valid        <= 1'b0;
      out_PCSrc       <= 1'b0;
      load_err        <= 1'b0;
      mem_timeout     <= 1'b0;
    end else begin
      rf_write_enable <= commit & c_rw & (c_rd != 5'd0) & ~c_err;
      wb_valid        <= commit;
      load_err        <= commit & c_err;
      mem_timeout     <= tmo;
      if (commit) begin
        rf_write_addr <= c_rd;
        rf_write_data <= sel_data;
        out_PCSrc     <= c_pcsrc;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        retired_count <= '0;
    else if (commit) retired_count <= retired_count + 64'd1;
  end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic vs a behavioural model.
module tb_writeback_stage;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 0, in_mem_done = 0, in_MemToReg = 0, in_RegWrite = 0, in_RegDataSrc = 0, in_PCSrc = 0;
  logic [31:0] in_alu_result = 0, in_pc_plus4 = 0, in_mem_data = 0;
  logic [2:0]  in_funct3 = 0;
  logic [4:0]  in_RegDest = 0;
  logic        stall, rf_write_enable, wb_valid, out_PCSrc, load_err, mem_timeout;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_count;
  longint unsigned seen_retired = 0;
`endif

  int checks = 0;
  int errors = 0;

  writeback_stage #(.XLEN(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .in_mem_data(in_mem_data), .in_mem_done(in_mem_done),
    .in_funct3(in_funct3), .in_MemToReg(in_MemToReg), .in_RegWrite(in_RegWrite),
    .in_RegDest(in_RegDest), .in_RegDataSrc(in_RegDataSrc), .in_PCSrc(in_PCSrc),
    .stall(stall), .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .wb_valid(wb_valid), .out_PCSrc(out_PCSrc),
    .load_err(load_err), .mem_timeout(mem_timeout)
`ifdef WB_RETIRE_CNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

`ifdef WB_RETIRE_CNT_EN
  always @(negedge clk) begin
    if (!rst) seen_retired = 0;
    else if (wb_valid === 1'b1) seen_retired = seen_retired + 1;
  end
`endif

  // Reference model: architectural result of one instruction
  function automatic void model(input bit m2r, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] mdata, input bit rw, input logic [4:0] rd,
                                input bit rds, input logic [31:0] pc4,
                                output logic [31:0] d, output bit we, output bit err);
    int unsigned a, b, h;
    a = alu % 4;
    b = (mdata >> (8 * a)) % 256;
    h = (mdata >> (16 * (a / 2))) % 65536;
    err = 0;
    d = 0;
    if (m2r) begin
      case (f3)
        3'd0: d = (b >= 128) ? b - 256 : b;
        3'd4: d = b;
        3'd1: if (a % 2 != 0) err = 1; else d = (h >= 32768) ? h - 65536 : h;
        3'd5: if (a % 2 != 0) err = 1; else d = h;
        3'd2: if (a != 0) err = 1; else d = mdata;
        default: err = 1;
      endcase
    end else begin
      d = rds ? pc4 : alu;
    end
    we = rw && (rd != 0) && !err;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m2r, input bit done, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] mdata, input bit rw, input logic [4:0] rd,
                       input bit rds, input bit pcs, input logic [31:0] pc4);
    in_valid = 1; in_MemToReg = m2r; in_mem_done = done; in_funct3 = f3; in_alu_result = alu;
    in_mem_data = mdata; in_RegWrite = rw; in_RegDest = rd; in_RegDataSrc = rds;
    in_PCSrc = pcs; in_pc_plus4 = pc4;
  endtask

  task automatic idle();
    in_valid = 0; in_MemToReg = 0; in_mem_done = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 3'd0, 32'h55, 32'h0, 1, 5'd4, 0, 1, 32'h0);
    #1 rst = 0;
    step(); step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_write_enable); end
    checks++; if ({rf_write_addr, rf_write_data, out_PCSrc, load_err, mem_timeout, stall} !== '0) begin
      errors++; $display("FAIL reset_outputs: addr %0h data %0h pcsrc %b lerr %b tmo %b stall %b want all 0",
                         rf_write_addr, rf_write_data, out_PCSrc, load_err, mem_timeout, stall); end
    idle();
    rst = 1;
    step();
  endtask

  task automatic test_alu();
    drive(0, 0, 3'd0, 32'h0000_00AB, 32'h0, 1, 5'd5, 0, 1, 32'h100);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
    step(); idle();
    checks++; if (rf_write_enable !== 1'b1) begin errors++; $display("FAIL alu_we: got %b want 1", rf_write_enable); end
    checks++; if (rf_write_addr !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d want 5", rf_write_addr); end
    checks++; if (rf_write_data !== 32'hAB) begin errors++; $display("FAIL alu_data: got %h want 000000ab", rf_write_data); end
    checks++; if (wb_valid !== 1'b1 || out_PCSrc !== 1'b1) begin errors++; $display("FAIL alu_valid_pcsrc: got %b%b want 11", wb_valid, out_PCSrc); end
    step();
    checks++; if (wb_valid !== 1'b0 || rf_write_enable !== 1'b0) begin errors++; $display("FAIL hold_pulses: got %b%b want 00", wb_valid, rf_write_enable); end
    checks++; if (rf_write_addr !== 5'd5 || rf_write_data !== 32'hAB || out_PCSrc !== 1'b1) begin
      errors++; $display("FAIL hold_values: got %0d %h %b want 5 000000ab 1", rf_write_addr, rf_write_data, out_PCSrc); end
    // pc_plus4 select
    drive(0, 0, 3'd0, 32'h1234, 32'h0, 1, 5'd6, 1, 0, 32'h0000_2008);
    step(); idle();
    checks++; if (rf_write_data !== 32'h2008 || out_PCSrc !== 1'b0) begin errors++; $display("FAIL link_data: got %h %b want 00002008 0", rf_write_data, out_PCSrc); end
  endtask

  task automatic test_load_same_cycle();
    drive(1, 1, 3'b000, 32'h0000_1001, 32'h1234_80FF, 1, 5'd7, 0, 0, 32'h0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall: got %b want 0", stall); end
    step();
    checks++; if (rf_write_data !== 32'hFFFF_FF80 || rf_write_enable !== 1'b1) begin errors++; $display("FAIL lb_data: got %h we %b want ffffff80 we 1", rf_write_data, rf_write_enable); end
    drive(1, 1, 3'b100, 32'h0000_1001, 32'h1234_80FF, 1, 5'd8, 0, 0, 32'h0);
    step(); idle();
    checks++; if (rf_write_data !== 32'h0000_0080 || rf_write_addr !== 5'd8) begin errors++; $display("FAIL lbu_data: got %h addr %0d want 00000080 addr 8", rf_write_data, rf_write_addr); end
  endtask

  task automatic test_delayed_lh();
    int stalls = 0;
    drive(1, 0, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 1, 5'd9, 0, 1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1 if (stall === 1'b1) stalls++;
      step();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lh_wait_valid: got %b want 0", wb_valid); end
    end
    in_mem_done = 1; in_mem_data = 32'h8001_0000;
    #1 if (stall === 1'b1) stalls++;
    step(); idle();
    checks++; if (stalls != 4) begin errors++; $display("FAIL lh_stall_cycles: got %0d want 4", stalls); end
    checks++; if (rf_write_data !== 32'hFFFF_8001 || wb_valid !== 1'b1 || rf_write_enable !== 1'b1) begin
      errors++; $display("FAIL lh_data: got %h v %b we %b want ffff8001 v 1 we 1", rf_write_data, wb_valid, rf_write_enable); end
    checks++; if (out_PCSrc !== 1'b1 || rf_write_addr !== 5'd9) begin errors++; $display("FAIL lh_ctrl: got %b %0d want 1 9", out_PCSrc, rf_write_addr); end
  endtask

  task automatic test_timeout();
    int waits = 0, pulses = 0, writes = 0;
    bit seen = 0;
    drive(1, 0, 3'b010, 32'h0000_3000, 32'h0, 1, 5'd10, 0, 0, 32'h0);
    for (int k = 0; k < 3 * MEM_TIMEOUT + 10; k++) begin
      step();
      if (rf_write_enable === 1'b1 || wb_valid === 1'b1) writes++;
      if (mem_timeout === 1'b1) begin pulses++; seen = 1; idle(); end
      else if (!seen && stall === 1'b1) waits++;
      if (seen && k > MEM_TIMEOUT + 4) break;
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_seen: got none want pulse within bound"); end
    checks++; if (waits != MEM_TIMEOUT) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want %0d", waits, MEM_TIMEOUT); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
    checks++; if (writes != 0) begin errors++; $display("FAIL timeout_writes: got %0d want 0", writes); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL timeout_stall_after: got %b want 0", stall); end
    drive(0, 0, 3'd0, 32'h0000_0C0D, 32'h0, 1, 5'd11, 0, 1, 32'h0);
    step(); idle();
    checks++; if (wb_valid !== 1'b1 || rf_write_data !== 32'h0C0D) begin errors++; $display("FAIL timeout_then_idle: got v %b %h want v 1 00000c0d", wb_valid, rf_write_data); end
  endtask

  task automatic test_errors();
    drive(1, 1, 3'b010, 32'h0000_4002, 32'hCAFE_F00D, 1, 5'd3, 0, 0, 32'h0);
    step();
    checks++; if (load_err !== 1'b1 || rf_write_enable !== 1'b0 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL lw_misaligned: got err %b we %b v %b want 1 0 1", load_err, rf_write_enable, wb_valid); end
    checks++; if (rf_write_data !== 32'h0) begin errors++; $display("FAIL lw_misaligned_data: got %h want 0", rf_write_data); end
    drive(0, 0, 3'd0, 32'h0000_7777, 32'h0, 1, 5'd0, 0, 0, 32'h0);
    step(); idle();
    checks++; if (rf_write_enable !== 1'b0 || wb_valid !== 1'b1 || load_err !== 1'b0) begin
      errors++; $display("FAIL x0_write: got we %b v %b err %b want 0 1 0", rf_write_enable, wb_valid, load_err); end
    step();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", load_err); end
  endtask

  task automatic test_reset_mid_wait();
    int late = 0;
    drive(1, 0, 3'b010, 32'h0000_5000, 32'h0, 1, 5'd12, 0, 1, 32'h0);
    step(); step();
    rst = 0;
    #1;
    checks++; if ({stall, rf_write_enable, rf_write_addr, rf_write_data, wb_valid, out_PCSrc, load_err, mem_timeout} !== '0) begin
      errors++; $display("FAIL midwait_reset: stall %b we %b addr %0d data %h v %b pcsrc %b want all 0",
                         stall, rf_write_enable, rf_write_addr, rf_write_data, wb_valid, out_PCSrc); end
    idle();
    step();
    rst = 1;
    in_mem_done = 1; in_mem_data = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      step();
      if (wb_valid === 1'b1 || rf_write_enable === 1'b1) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL midwait_late_write: got %0d want 0", late); end
    idle();
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] alu, mdata, pc4, ed;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit m2r, rw, rds, pcs, ewe, eerr;
    int delay;
    for (int n = 0; n < 150; n++) begin
      m2r = ($urandom % 2) == 1; rw = ($urandom % 4) != 0; rds = ($urandom % 2) == 1; pcs = ($urandom % 2) == 1;
      f3 = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
      alu = $urandom; mdata = $urandom; pc4 = $urandom;
      delay = m2r ? $urandom_range(0, 3) : 0;
      model(m2r, f3, alu, mdata, rw, rd, rds, pc4, ed, ewe, eerr);
      drive(m2r, delay == 0, f3, alu, (delay == 0) ? mdata : $urandom, rw, rd, rds, pcs, pc4);
      for (int k = 0; k < delay; k++) begin
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rnd_wait_valid n=%0d: got %b want 0", n, wb_valid); end
        if (k == delay - 1) begin in_mem_done = 1; in_mem_data = mdata; end
        else in_mem_data = $urandom;
      end
      step();
      checks++;
      if (wb_valid !== 1'b1 || rf_write_enable !== ewe || load_err !== eerr || mem_timeout !== 1'b0 ||
          rf_write_addr !== rd || rf_write_data !== ed || out_PCSrc !== pcs) begin
        errors++;
        $display("FAIL rnd_commit n=%0d: got v%b we%b err%b addr %0d data %h pc%b want v1 we%b err%b addr %0d data %h pc%b",
                 n, wb_valid, rf_write_enable, load_err, rf_write_addr, rf_write_data, out_PCSrc,
                 ewe, eerr, rd, ed, pcs);
      end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_same_cycle();
    test_delayed_lh();
    test_timeout();
    test_errors();
    test_reset_mid_wait();
    test_back_to_back_random();
`ifdef WB_RETIRE_CNT_EN
    checks++; if (retired_count !== 64'(seen_retired)) begin errors++; $display("FAIL retired_count: got %0d want %0d", retired_count, seen_retired); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
